// File: rtl/isa_pkg.sv
// Shared ISA definitions for the decode stage: opcodes, sign-extend modes,
// the EX control word layout and the decode controller state encoding.
package isa_pkg;

    localparam logic [4:0] OP_LOAD   = 5'b10000;
    localparam logic [4:0] OP_STORE  = 5'b10001;
    localparam logic [4:0] OP_BRANCH = 5'b10010;
    localparam logic [4:0] OP_JUMP   = 5'b10011;
    localparam logic [4:0] OP_HALT   = 5'b11110;
    localparam logic [4:0] OP_NOP    = 5'b11111;

    localparam logic [1:0] IMM_ALU = 2'b00;
    localparam logic [1:0] IMM_MEM = 2'b01;
    localparam logic [1:0] IMM_BR  = 2'b10;
    localparam logic [1:0] IMM_J   = 2'b11;

    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic       mem_to_reg;
        logic       alu_src;
        logic       branch;
        logic       jump;
        logic [2:0] alu_ctrl;
    } ctrl_t;

    typedef enum logic {RUN = 1'b0, HALT = 1'b1} ctl_state_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/main_decoder.sv
// Purely combinational opcode decoder: control word, sign-extend mode,
// source-register usage and halt/illegal classification.
module main_decoder
    import isa_pkg::*;
(
    input  logic [4:0] i_opcode,
    output ctrl_t      o_ctrl,
    output logic [1:0] o_imm_src,
    output logic       o_uses_rs1,
    output logic       o_uses_rs2,
    output logic       o_is_halt,
    output logic       o_is_illegal
);

    always_comb begin
        o_ctrl       = CTRL_BUBBLE;
        o_imm_src    = IMM_ALU;
        o_uses_rs1   = 1'b0;
        o_uses_rs2   = 1'b0;
        o_is_halt    = 1'b0;
        o_is_illegal = 1'b0;
        if (i_opcode[4:3] == 2'b00) begin
            o_ctrl.alu_ctrl  = i_opcode[2:0];
            o_ctrl.reg_write = 1'b1;
            o_uses_rs1       = 1'b1;
            o_uses_rs2       = 1'b1;
        end else if (i_opcode[4:3] == 2'b01) begin
            o_ctrl.alu_ctrl  = i_opcode[2:0];
            o_ctrl.alu_src   = 1'b1;
            o_ctrl.reg_write = 1'b1;
            o_uses_rs1       = 1'b1;
        end else begin
            case (i_opcode)
                OP_LOAD: begin
                    o_imm_src         = IMM_MEM;
                    o_ctrl.alu_src    = 1'b1;
                    o_ctrl.mem_to_reg = 1'b1;
                    o_ctrl.reg_write  = 1'b1;
                    o_uses_rs1        = 1'b1;
                end
                OP_STORE: begin
                    o_imm_src        = IMM_MEM;
                    o_ctrl.alu_src   = 1'b1;
                    o_ctrl.mem_write = 1'b1;
                    o_uses_rs1       = 1'b1;
                    o_uses_rs2       = 1'b1;
                end
                OP_BRANCH: begin
                    o_imm_src       = IMM_BR;
                    o_ctrl.branch   = 1'b1;
                    o_ctrl.alu_ctrl = 3'b001;
                    o_uses_rs1      = 1'b1;
                    o_uses_rs2      = 1'b1;
                end
                OP_JUMP: begin
                    o_imm_src   = IMM_J;
                    o_ctrl.jump = 1'b1;
                end
                OP_HALT: o_is_halt = 1'b1;
                OP_NOP:  ;
                default: o_is_illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/decode_ctrl.sv
// Decode-stage controller: ID/EX control register, load-use hazard detection,
// IF/ID stall/flush generation, halt sequencing and a saturating stall counter.
module decode_ctrl
    import isa_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      instr_d,
    input  logic             valid_d,
    input  logic             pc_src_e,
    output logic [1:0]       imm_src_d,
    output logic             reg_write_e,
    output logic             mem_write_e,
    output logic             mem_to_reg_e,
    output logic             alu_src_e,
    output logic             branch_e,
    output logic             jump_e,
    output logic [2:0]       alu_ctrl_e,
    output logic [3:0]       rd_e,
    output logic             stall_f,
    output logic             stall_d,
    output logic             flush_d,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] stall_cnt
);

    ctrl_t      w_dec_ctrl;
    logic       w_uses_rs1;
    logic       w_uses_rs2;
    logic       w_is_halt;
    logic       w_is_illegal;
    logic       w_is_bubble;
    logic       w_lu;
    logic       w_unused_imm;
    logic [3:0] w_rd;
    logic [3:0] w_rs1;
    logic [3:0] w_rs2;

    ctl_state_t r_state;
    ctl_state_t w_next_state;
    ctrl_t      r_ctrl;
    ctrl_t      w_ex_ctrl;
    logic [3:0] r_rd;
    logic [3:0] w_ex_rd;
    logic       r_illegal;
    logic       w_set_illegal;
    logic       w_cnt_inc;
    logic [CNT_W-1:0] r_cnt;

    assign w_rd  = instr_d[26:23];
    assign w_rs1 = instr_d[22:19];
    assign w_rs2 = instr_d[18:15];
    // The low immediate bits belong to sign_extend, not to control decode.
    assign w_unused_imm = ^instr_d[14:0];

    main_decoder u_main_decoder (
        .i_opcode     (instr_d[31:27]),
        .o_ctrl       (w_dec_ctrl),
        .o_imm_src    (imm_src_d),
        .o_uses_rs1   (w_uses_rs1),
        .o_uses_rs2   (w_uses_rs2),
        .o_is_halt    (w_is_halt),
        .o_is_illegal (w_is_illegal)
    );

    assign w_is_bubble = w_is_halt | w_is_illegal | (instr_d[31:27] == OP_NOP);

    assign w_lu = valid_d && r_ctrl.mem_to_reg && (r_rd != 4'd0) &&
                  ((w_uses_rs1 && (w_rs1 == r_rd)) || (w_uses_rs2 && (w_rs2 == r_rd)));

    // Priority: HALT freezes everything, then flush, then load-use, then issue.
    always_comb begin
        w_next_state  = r_state;
        stall_f       = 1'b0;
        stall_d       = 1'b0;
        flush_d       = 1'b0;
        w_ex_ctrl     = CTRL_BUBBLE;
        w_ex_rd       = 4'd0;
        w_set_illegal = 1'b0;
        w_cnt_inc     = 1'b0;
        unique case (r_state)
            HALT: begin
                stall_f = 1'b1;
                stall_d = 1'b1;
            end
            RUN: begin
                if (pc_src_e) begin
                    flush_d = 1'b1;
                end else if (w_lu) begin
                    stall_f   = 1'b1;
                    stall_d   = 1'b1;
                    w_cnt_inc = 1'b1;
                end else if (valid_d) begin
                    w_ex_ctrl     = w_dec_ctrl;
                    w_ex_rd       = w_is_bubble ? 4'd0 : w_rd;
                    w_set_illegal = w_is_illegal;
                    if (w_is_halt) w_next_state = HALT;
                end
            end
            default: w_next_state = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= RUN;
            r_ctrl    <= CTRL_BUBBLE;
            r_rd      <= 4'd0;
            r_illegal <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_state <= w_next_state;
            r_ctrl  <= w_ex_ctrl;
            r_rd    <= w_ex_rd;
            if (w_set_illegal) r_illegal <= 1'b1;
            if (w_cnt_inc && (r_cnt != {CNT_W{1'b1}})) r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign reg_write_e  = r_ctrl.reg_write;
    assign mem_write_e  = r_ctrl.mem_write;
    assign mem_to_reg_e = r_ctrl.mem_to_reg;
    assign alu_src_e    = r_ctrl.alu_src;
    assign branch_e     = r_ctrl.branch;
    assign jump_e       = r_ctrl.jump;
    assign alu_ctrl_e   = r_ctrl.alu_ctrl;
    assign rd_e         = r_rd;
    assign halted       = (r_state == HALT);
    assign illegal      = r_illegal;
    assign stall_cnt    = r_cnt;

endmodule

// File: tb/tb_decode_ctrl.sv
// Bench for decode_ctrl: reference decode model, EX-word scoreboard queue,
// directed hazard/flush/halt/reset scenarios plus a random instruction stream.
module tb_decode_ctrl;

  localparam int W = 13;  // {reg_write, mem_write, mem_to_reg, alu_src, branch, jump, alu_ctrl[2:0], rd[3:0]}

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr_d;
  logic        valid_d;
  logic        pc_src_e;

  logic [1:0]  imm_src_d, imm_src_d2;
  logic        reg_write_e, mem_write_e, mem_to_reg_e, alu_src_e, branch_e, jump_e;
  logic [2:0]  alu_ctrl_e;
  logic [3:0]  rd_e;
  logic        stall_f, stall_d, flush_d, halted, illegal;
  logic [15:0] stall_cnt;

  logic        reg_write_e2, mem_write_e2, mem_to_reg_e2, alu_src_e2, branch_e2, jump_e2;
  logic [2:0]  alu_ctrl_e2;
  logic [3:0]  rd_e2;
  logic        stall_f2, stall_d2, flush_d2, halted2, illegal2;
  logic [1:0]  stall_cnt2;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  decode_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .instr_d(instr_d), .valid_d(valid_d), .pc_src_e(pc_src_e),
    .imm_src_d(imm_src_d), .reg_write_e(reg_write_e), .mem_write_e(mem_write_e),
    .mem_to_reg_e(mem_to_reg_e), .alu_src_e(alu_src_e), .branch_e(branch_e), .jump_e(jump_e),
    .alu_ctrl_e(alu_ctrl_e), .rd_e(rd_e), .stall_f(stall_f), .stall_d(stall_d),
    .flush_d(flush_d), .halted(halted), .illegal(illegal), .stall_cnt(stall_cnt)
  );

  decode_ctrl #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .instr_d(instr_d), .valid_d(valid_d), .pc_src_e(pc_src_e),
    .imm_src_d(imm_src_d2), .reg_write_e(reg_write_e2), .mem_write_e(mem_write_e2),
    .mem_to_reg_e(mem_to_reg_e2), .alu_src_e(alu_src_e2), .branch_e(branch_e2), .jump_e(jump_e2),
    .alu_ctrl_e(alu_ctrl_e2), .rd_e(rd_e2), .stall_f(stall_f2), .stall_d(stall_d2),
    .flush_d(flush_d2), .halted(halted2), .illegal(illegal2), .stall_cnt(stall_cnt2)
  );

  // ---------------- scoreboard / model state ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];
  logic         m_halted;
  logic         m_illegal;
  logic [15:0]  m_cnt;
  logic [1:0]   m_cnt2;
  logic [W-1:0] m_ex;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Returns {ctrl[8:0], imm_src[1:0], uses_rs1, uses_rs2, is_halt, is_illegal}.
  // ctrl = {reg_write, mem_write, mem_to_reg, alu_src, branch, jump, alu_ctrl}.
  function automatic logic [14:0] ref_dec(input logic [4:0] op);
    logic [8:0] c;
    logic [1:0] im;
    logic u1, u2, h, il;
    c = '0; im = 2'b00; u1 = 0; u2 = 0; h = 0; il = 0;
    if (op < 5'd8) begin
      c = {1'b1, 5'b00000, op[2:0]}; u1 = 1; u2 = 1;
    end else if (op < 5'd16) begin
      c = {1'b1, 2'b00, 1'b1, 2'b00, op[2:0]}; u1 = 1;
    end else if (op == 5'd16) begin
      c = 9'b1_0_1_1_0_0_000; im = 2'b01; u1 = 1;
    end else if (op == 5'd17) begin
      c = 9'b0_1_0_1_0_0_000; im = 2'b01; u1 = 1; u2 = 1;
    end else if (op == 5'd18) begin
      c = 9'b0_0_0_0_1_0_001; im = 2'b10; u1 = 1; u2 = 1;
    end else if (op == 5'd19) begin
      c = 9'b0_0_0_0_0_1_000; im = 2'b11;
    end else if (op == 5'd30) begin
      h = 1;
    end else if (op != 5'd31) begin
      il = 1;
    end
    return {c, im, u1, u2, h, il};
  endfunction

  function automatic logic [31:0] mk(input logic [4:0] op, input logic [3:0] rd,
                                     input logic [3:0] rs1, input logic [3:0] rs2);
    return {op, rd, rs1, rs2, 15'h1234};
  endfunction

  function automatic logic [W-1:0] ex_word();
    return {reg_write_e, mem_write_e, mem_to_reg_e, alu_src_e, branch_e, jump_e, alu_ctrl_e, rd_e};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic apply(input logic [31:0] ins, input logic v, input logic pc);
    logic [14:0]  d;
    logic         lu, e_stall, e_flush, n_halted, n_illegal, n_inc;
    logic [W-1:0] nxt, e;
    @(negedge clk);
    instr_d = ins; valid_d = v; pc_src_e = pc;
    #1;
    d = ref_dec(ins[31:27]);
    lu = v && m_ex[10] && (m_ex[3:0] != 4'd0) &&
         ((d[3] && ins[22:19] == m_ex[3:0]) || (d[2] && ins[18:15] == m_ex[3:0]));
    e_stall = 0; e_flush = 0; n_inc = 0; nxt = '0;
    n_halted = m_halted; n_illegal = m_illegal;
    if (m_halted) e_stall = 1;
    else if (pc) e_flush = 1;
    else if (lu) begin e_stall = 1; n_inc = 1; end
    else if (v) begin
      if (!d[1] && !d[0] && ins[31:27] != 5'd31) nxt = {d[14:6], ins[26:23]};
      if (d[1]) n_halted = 1;
      if (d[0]) n_illegal = 1;
    end
    check_val("imm_src_d", imm_src_d, d[5:4]);
    check_val("stall_f", stall_f, e_stall);
    check_val("stall_d", stall_d, e_stall);
    check_val("flush_d", flush_d, e_flush);
    check_val("halted_pre", halted, m_halted);
    exp_q.push_back(nxt);
    @(posedge clk);
    #1;
    m_halted = n_halted; m_illegal = n_illegal; m_ex = nxt;
    if (n_inc && m_cnt != 16'hffff) m_cnt = m_cnt + 16'd1;
    if (n_inc && m_cnt2 != 2'b11) m_cnt2 = m_cnt2 + 2'd1;
    check_val("sb_depth", exp_q.size(), 1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check_val("ex_word", ex_word(), e);
    end
    check_val("halted", halted, m_halted);
    check_val("illegal", illegal, m_illegal);
    check_val("stall_cnt", stall_cnt, m_cnt);
    check_val("stall_cnt_w2", stall_cnt2, m_cnt2);
  endtask

  task automatic check_reset_zero(input string tag);
    check_val({tag, "_ex"}, ex_word(), '0);
    check_val({tag, "_halted"}, halted, 0);
    check_val({tag, "_illegal"}, illegal, 0);
    check_val({tag, "_cnt"}, stall_cnt, 0);
    check_val({tag, "_cnt_w2"}, stall_cnt2, 0);
    check_val({tag, "_stalls"}, {stall_f, stall_d, flush_d}, 0);
    check_val({tag, "_imm"}, imm_src_d, 0);
  endtask

  // Asserts reset between clock edges so the check sees the asynchronous path.
  task automatic do_reset();
    @(posedge clk);
    #3;
    instr_d = '0; valid_d = 0; pc_src_e = 0;
    rst_n = 0;
    #1;
    check_reset_zero("rst_async");
    m_halted = 0; m_illegal = 0; m_cnt = '0; m_cnt2 = '0; m_ex = '0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic load_use_pair(input logic pc);
    apply(mk(5'b10000, 4'd3, 4'd0, 4'd0), 1, 0);
    apply(mk(5'b00000, 4'd5, 4'd3, 4'd1), 1, pc);
    apply(mk(5'b00000, 4'd5, 4'd3, 4'd1), 1, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [4:0] op;
    rst_n = 0; instr_d = '0; valid_d = 0; pc_src_e = 0;
    m_halted = 0; m_illegal = 0; m_cnt = '0; m_cnt2 = '0; m_ex = '0;
    #2;
    check_reset_zero("rst_init");
    @(negedge clk);
    rst_n = 1;

    // Random legal, non-halting stream with occasional bubbles and flushes.
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 6))
        0: op = {2'b00, 3'($urandom_range(0, 7))};
        1: op = {2'b01, 3'($urandom_range(0, 7))};
        2: op = 5'b10000;
        3: op = 5'b10001;
        4: op = 5'b10010;
        5: op = 5'b10011;
        default: op = 5'b11111;
      endcase
      apply(mk(op, 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))),
            $urandom_range(0, 7) != 0, $urandom_range(0, 9) == 0);
    end

    do_reset();

    apply(32'h8000_0000, 1, 0);
    check_val("load_ctrl", {mem_to_reg_e, reg_write_e, alu_src_e, alu_ctrl_e}, 6'b111_000);

    load_use_pair(0);
    check_val("lu_cnt_one", stall_cnt, 1);

    load_use_pair(1);
    check_val("flush_cnt_hold", stall_cnt, 1);

    for (int i = 0; i < 4; i++) load_use_pair(0);
    check_val("cnt_five", stall_cnt, 5);
    check_val("cnt_w2_sat", stall_cnt2, 3);

    apply(mk(5'b10100, 4'd2, 4'd1, 4'd1), 1, 0);
    check_val("illegal_set", illegal, 1);
    apply(mk(5'b11110, 4'd0, 4'd0, 4'd0), 1, 0);
    for (int i = 0; i < 12; i++)
      apply((i % 2 == 0) ? mk(5'b10000, 4'd3, 4'd0, 4'd0) : mk(5'b00000, 4'd4, 4'd3, 4'd3), 1, i[0]);
    check_val("halt_hold", {halted, stall_f, illegal}, 3'b111);

    do_reset();
    apply(mk(5'b11111, 4'd0, 4'd0, 4'd0), 1, 0);
    apply(mk(5'b01010, 4'd7, 4'd2, 4'd0), 1, 0);
    check_val("run_after_rst", halted, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
